e_mdu_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit for the E stage, beside the E-stage ALU.

---
 rtl/e_mdu_sequencer.sv | 151 +++++++++++++++
 tb/tb_e_mdu_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_sequencer.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU with a fixed
// busy latency, serves MTHI/MTLO/MFHI/MFLO and raises the D-stage stall.
//
// state | meaning
// IDLE  | no operation pending; MTHI/MTLO write, a start request is accepted
// RUN   | result held in pend_hi/pend_lo, cnt counts down to the commit edge
module e_mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_MDStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_IsMD,
    output logic        E_Busy,
    output logic        E_MDStall,
    output logic [31:0] E_MDOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi, hi_nxt, lo, lo_nxt;
    logic [31:0] pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic        pend_wr, pend_wr_nxt;
    logic        start_eff;

    logic [63:0] prod_s, prod_u;
    logic [31:0] divisor, a_mag, b_mag;
    logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

    assign start_eff = E_MDStart && (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU)
                       && (state == IDLE);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divisor forced to 1 on B==0 so the dividers never see zero; that result is discarded.
    assign divisor = (B == 32'd0) ? 32'd1 : B;
    assign uq      = A / divisor;
    assign ur      = A % divisor;

    // Signed divide on magnitudes; MIN/-1 wraps back to 0x80000000 with remainder 0.
    assign a_mag  = A[31] ? (32'd0 - A) : A;
    assign b_mag  = divisor[31] ? (32'd0 - divisor) : divisor;
    assign sq_mag = a_mag / b_mag;
    assign sr_mag = a_mag % b_mag;
    assign sq     = (A[31] ^ divisor[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr     = A[31] ? (32'd0 - sr_mag) : sr_mag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        case (state)
            IDLE: begin
                if (start_eff) begin
                    state_nxt   = RUN;
                    pend_wr_nxt = 1'b1;
                    case (E_MDOp)
                        OP_MULT: begin
                            {pend_hi_nxt, pend_lo_nxt} = prod_s;
                            cnt_nxt = MULT_N;
                        end
                        OP_MULTU: begin
                            {pend_hi_nxt, pend_lo_nxt} = prod_u;
                            cnt_nxt = MULT_N;
                        end
                        OP_DIV: begin
                            pend_hi_nxt = sr;
                            pend_lo_nxt = sq;
                            pend_wr_nxt = (B != 32'd0);
                            cnt_nxt     = DIV_N;
                        end
                        default: begin
                            pend_hi_nxt = ur;
                            pend_lo_nxt = uq;
                            pend_wr_nxt = (B != 32'd0);
                            cnt_nxt     = DIV_N;
                        end
                    endcase
                end else if (E_MDOp == OP_MTHI) begin
                    hi_nxt = A;
                end else if (E_MDOp == OP_MTLO) begin
                    lo_nxt = A;
                end
            end
            RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign E_Busy    = (state == RUN);
    assign E_MDStall = D_IsMD && (start_eff || E_Busy);

    always_comb begin
        E_MDOut = 32'd0;
        if (E_MDOp == OP_MFHI)      E_MDOut = hi;
        else if (E_MDOp == OP_MFLO) E_MDOut = lo;
    end

endmodule

// File: tb/tb_e_mdu_sequencer.sv
// Scoreboard bench for e_mdu_sequencer: directed scenarios then random traffic,
// expectations from a cycle-level arithmetic model of HI/LO and the busy window.
module tb_e_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic        E_MDStart;
    logic [31:0] A, B;
    logic        D_IsMD;
    logic        E_Busy, E_MDStall;
    logic [31:0] E_MDOut;

    e_mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_MDStart(E_MDStart),
        .A(A), .B(B), .D_IsMD(D_IsMD),
        .E_Busy(E_Busy), .E_MDStall(E_MDStall), .E_MDOut(E_MDOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        stall;
        logic [31:0] out;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_id = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwr;
    int          m_left;
    bit          m_valid = 0;

    function automatic void compute(input logic [3:0] op, input logic [31:0] a, b,
                                    output logic [31:0] rhi, rlo, output logic wr);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        wr = 1'b1;
        rhi = 32'd0;
        rlo = 32'd0;
        case (op)
            4'd1: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; rhi = p[63:32]; rlo = p[31:0]; end
            4'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    q = sa / sb; r = sa % sb;
                    p = q; rlo = p[31:0];
                    p = r; rhi = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin rlo = a / b; rhi = a % b; end
            end
        endcase
    endfunction

    task automatic step(input logic [3:0] op, input logic st, input logic [31:0] a, b,
                        input logic dis, input logic rst);
        exp_t e;
        logic se;
        E_MDOp = op; E_MDStart = st; A = a; B = b; D_IsMD = dis; reset = rst;
        se = st && (op >= 4'd1) && (op <= 4'd4) && (m_left == 0);
        if (m_valid) begin
            e.busy  = (m_left > 0);
            e.stall = dis && (se || (m_left > 0));
            e.out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
            e.id    = cyc_id;
            exp_q.push_back(e);
        end
        cyc_id++;
        @(posedge clk);
        if (!rst) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_left = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (se) begin
                compute(op, a, b, m_phi, m_plo, m_pwr);
                m_left = (op <= 4'd2) ? 5 : 10;
            end else if (op == 4'd5) m_hi = a;
            else if (op == 4'd6) m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic dis);
        for (int i = 0; i < n; i++) step(4'd0, 1'b0, 32'd0, 32'd0, dis, 1'b1);
    endtask

    task automatic read_both(input logic dis);
        step(4'd8, 1'b0, 32'd0, 32'd0, dis, 1'b1);
        step(4'd7, 1'b0, 32'd0, 32'd0, dis, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (E_Busy !== e.busy) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b want %b", e.id, E_Busy, e.busy);
            end
            checks++;
            if (E_MDStall !== e.stall) begin
                errors++;
                $display("FAIL stall cycle %0d: got %b want %b", e.id, E_MDStall, e.stall);
            end
            checks++;
            if (E_MDOut !== e.out) begin
                errors++;
                $display("FAIL mdout cycle %0d: got %h want %h", e.id, E_MDOut, e.out);
            end
        end
    end

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic        st;
        logic [31:0] a, b;

        // reset held two cycles, then reads of cleared HI/LO with D_IsMD high
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        read_both(1'b1);

        step(4'd1, 1'b1, 32'd3, 32'hFFFF_FFFE, 1'b0, 1'b1);
        idle(5, 1'b0);
        read_both(1'b0);

        step(4'd4, 1'b1, 32'd7, 32'd2, 1'b0, 1'b1);
        idle(10, 1'b0);
        read_both(1'b0);
        step(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        idle(10, 1'b0);
        read_both(1'b0);

        step(4'd5, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b1);
        step(4'd3, 1'b1, 32'd5, 32'd0, 1'b0, 1'b1);
        idle(10, 1'b0);
        read_both(1'b0);

        step(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        idle(10, 1'b0);
        read_both(1'b0);

        // reset lands in the third busy cycle of a MULTU
        step(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(6, 1'b0);
        read_both(1'b0);

        // stall during RUN; start and MTLO issued while busy are dropped
        step(4'd1, 1'b1, 32'd6, 32'd7, 1'b1, 1'b1);
        step(4'd1, 1'b1, 32'd9, 32'd9, 1'b1, 1'b1);
        step(4'd6, 1'b0, 32'h55, 32'd0, 1'b1, 1'b1);
        step(4'd8, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(2, 1'b1);
        read_both(1'b1);
        idle(2, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 8));
            if (op >= 4'd1 && op <= 4'd4) st = ($urandom_range(0, 7) != 0);
            else                          st = ($urandom_range(0, 15) == 0);
            a = pick32();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick32();
            step(op, st, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) != 0));
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
